de2_board_io: RTL and testbench
===============================

# de2_board_io

AHB-Lite slave giving the core register access to the DE2-115 board I/O: 18 red LEDs, 9 green LEDs, eight 7-segment digits, 18 slide switches and 4 push-buttons with press-interrupt. It sits directly downstream of the uncore address decoder, next to the GPIO/UART/PLIC peripherals, and drives the FPGA pins. Its interrupt output feeds a PLIC source.

## Interface
- DEBOUNCE_CYCLES, 500000: cycles an input must hold a new value before it is accepted (10 ms at 50 MHz).
- clk  in  1  core clock; all logic single-clock.
- reset  in  1  synchronous, active-high reset.
- HSELDE2IO  in  1  slave select from uncore decoder.
- HADDR  in  8  byte offset within the block.
- HWRITE  in  1  AHB write.
- HTRANS  in  2  AHB transfer type; bit 1 set means NONSEQ/SEQ.
- HREADY  in  1  bus ready.
- HWDATA  in  32  write data, data phase.
- HREADDE2IO  out  32  read data, data phase.
- HREADYDE2IO  out  1  constant 1 (zero wait states).
- HRESPDE2IO  out  1  constant 0 (OKAY).
- SW  in  18  raw switch pins, asynchronous.
- KEY  in  4  raw button pins, asynchronous, active-low.
- LEDR  out  18  red LEDs. LEDG  out  9  green LEDs.
- HEX  out  56  digit i at [7i+6:7i], segments active-low, gfedcba order.
- DE2IOIntr  out  1  level interrupt to PLIC.

## Operation
- Register map, word access only, HSIZE ignored:
  - 0x00 LEDR (RW, 18b).
  - 0x04 LEDG (RW, 9b).
  - 0x08 HEXVAL (RW, 32b; nibble i = digit i).
  - 0x0C HEXEN (RW, 8b).
  - 0x10 SWSTAT (RO).
  - 0x14 KEYSTAT (RO, 4b, 1 = pressed).
  - 0x18 KEYIE (RW, 4b).
  - 0x1C KEYIP (W1C, 4b).
- Other offsets read 0. Writes to them and to RO registers are ignored. Unused upper bits read 0.
- Input path per bit:
  - Two-flop synchronizer. KEY is inverted before it.
  - Debouncer: a stable value plus a counter. The counter increments while the synchronized bit differs from the stable value and clears when they match. When it reaches DEBOUNCE_CYCLES, the stable value is updated and the counter clears.
- KEYIP[i] sets on a 0→1 transition of the debounced KEYSTAT[i].
  - A KEYIP write with bit i = 1 clears KEYIP[i].
  - If set and clear land in the same cycle, set wins.
- DE2IOIntr = |(KEYIP & KEYIE), taken straight from registers.
- HEX digit i = hex-to-7-seg(HEXVAL[4i+3:4i]) when HEXEN[i]; otherwise 7'h7F (blank).

## Timing
- Address phase is accepted when HSELDE2IO & HREADY & HTRANS[1]. Offset and HWRITE are registered at that point.
- Write: HWDATA is sampled in the data phase. The register updates on the clock edge that ends the data phase.
- Read: HREADDE2IO is a combinational mux of the registered offset over current register state, valid throughout the data phase.
- Back-to-back write then read of the same register returns the new value.
- LED and HEX pins change 1 cycle after the write data phase ends.
- Input latency: a pin change reaches the status register after 2 sync cycles + DEBOUNCE_CYCLES + 1. Glitches shorter than DEBOUNCE_CYCLES are rejected.
- DE2IOIntr asserts in the cycle after KEYIP sets.
- Reset values:
  - All RW registers, KEYIP, synchronizers, stable values and counters reset to 0. Keys read as released and switches as 0.
  - LEDR/LEDG = 0, HEX = all 7'h7F, DE2IOIntr = 0, HREADDE2IO = 0, no captured transfer.
- Reset mid-transfer abandons the pending data phase; no register is written.
- The debounce counter never wraps: it saturates at DEBOUNCE_CYCLES and clears in the same edge.

## Configuration
- DE2IO_DEBOUNCE_EN:
  - Defined: debouncers as above.
  - Undefined: the stable value equals the synchronizer output (latency 2 cycles), counters are removed, and DEBOUNCE_CYCLES is unused.

## Structure
- Shared package constants:
  - DE2IO_BASE = 64'h10070000 and DE2IO_RANGE = 64'h000000FF, alongside the other peripheral addresses.
  - Register-offset localparams.
  - PLIC_DE2IO_ID = 32'd4.
- Sub-module de2_debounce: one synchronizer + debouncer per bit, parameterized by width and DEBOUNCE_CYCLES. Instantiated once for SW (18 bits) and once for KEY (4 bits).
- The 7-seg decode is an inline function.

## Test plan
- Reset, then read all 8 offsets → all 0; HEX = 56 bits of 1; DE2IOIntr = 0.
- Write LEDR = 0xFFFFFFFF, then read → 0x0003FFFF; LEDR pins all 1 one cycle after the data phase. Write LEDG = 0x1A5 → LEDG = 9'h1A5.
- Write HEXVAL = 0x89ABCDEF and HEXEN = 0x01 → HEX[6:0] = 7'h0E ('F'), others 7'h7F. Then HEXEN = 0xFF → digit 7 = 7'h00 ('8').
- With DEBOUNCE_CYCLES = 4:
  - SW[3] is raised for 3 cycles then dropped → SWSTAT stays 0.
  - SW[3] is held → SWSTAT = 0x8 exactly 7 cycles after the pin change.
- With DEBOUNCE_CYCLES = 4 and KEYIE = 0x2:
  - KEY[1] driven low → KEYIP = 0x2 and DE2IOIntr = 1.
  - Write KEYIP = 0x2 → both clear. A second press in the same cycle as the W1C write leaves KEYIP[1] = 1.
- Read of offset 0x40 → 0. Write to SWSTAT → no change. Reset asserted during a write data phase → target register remains 0.

Source files
------------

// File: rtl/de2_board_io_pkg.sv
// Shared constants, register map and bus payload type for the DE2-115 board I/O slave.
package de2_board_io_pkg;

  localparam logic [63:0] DE2IO_BASE    = 64'h10070000;
  localparam logic [63:0] DE2IO_RANGE   = 64'h000000FF;
  localparam logic [31:0] PLIC_DE2IO_ID = 32'd4;

  localparam int unsigned HADDR_W    = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SW_W       = 18;
  localparam int unsigned KEY_W      = 4;
  localparam int unsigned LEDR_W     = 18;
  localparam int unsigned LEDG_W     = 9;
  localparam int unsigned HEX_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;

  localparam logic [HADDR_W-1:0] OFF_LEDR    = 8'h00;
  localparam logic [HADDR_W-1:0] OFF_LEDG    = 8'h04;
  localparam logic [HADDR_W-1:0] OFF_HEXVAL  = 8'h08;
  localparam logic [HADDR_W-1:0] OFF_HEXEN   = 8'h0C;
  localparam logic [HADDR_W-1:0] OFF_SWSTAT  = 8'h10;
  localparam logic [HADDR_W-1:0] OFF_KEYSTAT = 8'h14;
  localparam logic [HADDR_W-1:0] OFF_KEYIE   = 8'h18;
  localparam logic [HADDR_W-1:0] OFF_KEYIP   = 8'h1C;

  // Address-phase information carried into the data phase.
  typedef struct packed {
    logic               valid;
    logic               write;
    logic [HADDR_W-1:0] offset;
  } ahb_dphase_t;

endpackage

// File: rtl/de2_debounce.sv
// Per-bit two-flop synchronizer plus counter debouncer.
// DE2IO_DEBOUNCE_EN: when undefined the output is the bare synchronizer output.
module de2_debounce #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

`ifdef DE2IO_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
    end
  end

  if (DEB_EN && (DEBOUNCE_CYCLES > 0)) begin : g_deb
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic             stable_q;
      logic [CNT_W-1:0] cnt_q;

      // Counter saturates at the threshold and clears on the same edge the value is accepted.
      always_ff @(posedge clk) begin
        if (reset) begin
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else if (sync2_q[i] == stable_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
          stable_q <= sync2_q[i];
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      assign dout_o[i] = stable_q;
    end
  end else begin : g_nodeb
    assign dout_o = sync2_q;
  end

endmodule

// File: rtl/de2_board_io.sv
// AHB-Lite slave for DE2-115 LEDs, 7-segment digits, switches and push-buttons with interrupt.
// DE2IO_DEBOUNCE_EN enables the input debouncers (otherwise inputs are only synchronized).
module de2_board_io
  import de2_board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          HSELDE2IO,
  input  logic [HADDR_W-1:0]            HADDR,
  input  logic                          HWRITE,
  input  logic [1:0]                    HTRANS,
  input  logic                          HREADY,
  input  logic [DATA_W-1:0]             HWDATA,
  output logic [DATA_W-1:0]             HREADDE2IO,
  output logic                          HREADYDE2IO,
  output logic                          HRESPDE2IO,
  input  logic [SW_W-1:0]               SW,
  input  logic [KEY_W-1:0]              KEY,
  output logic [LEDR_W-1:0]             LEDR,
  output logic [LEDG_W-1:0]             LEDG,
  output logic [HEX_DIGITS*SEG_W-1:0]   HEX,
  output logic                          DE2IOIntr
);

  function automatic logic [SEG_W-1:0] hex7seg(input logic [3:0] v);
    logic [SEG_W-1:0] on;
    case (v)
      4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
      4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
      4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
      4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  ahb_dphase_t bus_d, bus_q;

  logic [LEDR_W-1:0]           ledr_d, ledr_q;
  logic [LEDG_W-1:0]           ledg_d, ledg_q;
  logic [DATA_W-1:0]           hexval_d, hexval_q;
  logic [HEX_DIGITS-1:0]       hexen_d, hexen_q;
  logic [KEY_W-1:0]            keyie_d, keyie_q;
  logic [KEY_W-1:0]            keyip_d, keyip_q;
  logic [KEY_W-1:0]            keyip_clr;
  logic [KEY_W-1:0]            key_prev_q;
  logic [HEX_DIGITS*SEG_W-1:0] hex_d, hex_q;
  logic                        intr_d, intr_q;
  logic [SW_W-1:0]             sw_stat;
  logic [KEY_W-1:0]            key_stat;
  logic [DATA_W-1:0]           rdata_c;
  logic                        unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  de2_debounce #(.WIDTH(SW_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_deb (
    .clk    (clk),
    .reset  (reset),
    .din_i  (SW),
    .dout_o (sw_stat)
  );

  // Buttons are active-low on the board; invert so 1 means pressed.
  de2_debounce #(.WIDTH(KEY_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_deb (
    .clk    (clk),
    .reset  (reset),
    .din_i  (~KEY),
    .dout_o (key_stat)
  );

  always_comb begin
    bus_d.valid  = HSELDE2IO & HREADY & HTRANS[1];
    bus_d.write  = HWRITE;
    bus_d.offset = HADDR;
  end

  // Register write decode, W1C with set priority, and registered pin images.
  always_comb begin
    ledr_d    = ledr_q;
    ledg_d    = ledg_q;
    hexval_d  = hexval_q;
    hexen_d   = hexen_q;
    keyie_d   = keyie_q;
    keyip_clr = '0;
    if (bus_q.valid && bus_q.write) begin
      case (bus_q.offset)
        OFF_LEDR:   ledr_d    = HWDATA[LEDR_W-1:0];
        OFF_LEDG:   ledg_d    = HWDATA[LEDG_W-1:0];
        OFF_HEXVAL: hexval_d  = HWDATA;
        OFF_HEXEN:  hexen_d   = HWDATA[HEX_DIGITS-1:0];
        OFF_KEYIE:  keyie_d   = HWDATA[KEY_W-1:0];
        OFF_KEYIP:  keyip_clr = HWDATA[KEY_W-1:0];
        default: ;
      endcase
    end
    keyip_d = (keyip_q & ~keyip_clr) | (key_stat & ~key_prev_q);
    intr_d  = |(keyip_d & keyie_d);
    hex_d   = '1;
    for (int i = 0; i < HEX_DIGITS; i++) begin
      if (hexen_d[i]) hex_d[SEG_W*i +: SEG_W] = hex7seg(hexval_d[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_q      <= '0;
      ledr_q     <= '0;
      ledg_q     <= '0;
      hexval_q   <= '0;
      hexen_q    <= '0;
      keyie_q    <= '0;
      keyip_q    <= '0;
      key_prev_q <= '0;
      hex_q      <= '1;
      intr_q     <= 1'b0;
    end else begin
      if (HREADY) bus_q <= bus_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      hexval_q   <= hexval_d;
      hexen_q    <= hexen_d;
      keyie_q    <= keyie_d;
      keyip_q    <= keyip_d;
      key_prev_q <= key_stat;
      hex_q      <= hex_d;
      intr_q     <= intr_d;
    end
  end

  // Read data is combinational over current state so a write is visible to the very next read.
  always_comb begin
    rdata_c = '0;
    if (bus_q.valid && !bus_q.write) begin
      case (bus_q.offset)
        OFF_LEDR:    rdata_c = DATA_W'(ledr_q);
        OFF_LEDG:    rdata_c = DATA_W'(ledg_q);
        OFF_HEXVAL:  rdata_c = hexval_q;
        OFF_HEXEN:   rdata_c = DATA_W'(hexen_q);
        OFF_SWSTAT:  rdata_c = DATA_W'(sw_stat);
        OFF_KEYSTAT: rdata_c = DATA_W'(key_stat);
        OFF_KEYIE:   rdata_c = DATA_W'(keyie_q);
        OFF_KEYIP:   rdata_c = DATA_W'(keyip_q);
        default:     rdata_c = '0;
      endcase
    end
  end

  assign HREADDE2IO  = rdata_c;
  assign HREADYDE2IO = 1'b1;
  assign HRESPDE2IO  = 1'b0;
  assign LEDR        = ledr_q;
  assign LEDG        = ledg_q;
  assign HEX         = hex_q;
  assign DE2IOIntr   = intr_q;

endmodule

// File: tb/tb_de2_board_io.sv
// Directed self-checking bench for de2_board_io (bus, pins, inputs and key interrupt).
module tb_de2_board_io;

  localparam int unsigned DC = 4;
`ifdef DE2IO_DEBOUNCE_EN
  localparam int unsigned LAT = DC + 3;
`else
  localparam int unsigned LAT = 2;
`endif

  logic        clk;
  logic        reset;
  logic        HSELDE2IO;
  logic [7:0]  HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic [31:0] HREADDE2IO;
  logic        HREADYDE2IO;
  logic        HRESPDE2IO;
  logic [17:0] SW;
  logic [3:0]  KEY;
  logic [17:0] LEDR;
  logic [8:0]  LEDG;
  logic [55:0] HEX;
  logic        DE2IOIntr;

  int checks = 0;
  int errors = 0;

  de2_board_io #(.DEBOUNCE_CYCLES(DC)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .HSELDE2IO   (HSELDE2IO),
    .HADDR       (HADDR),
    .HWRITE      (HWRITE),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HWDATA      (HWDATA),
    .HREADDE2IO  (HREADDE2IO),
    .HREADYDE2IO (HREADYDE2IO),
    .HRESPDE2IO  (HRESPDE2IO),
    .SW          (SW),
    .KEY         (KEY),
    .LEDR        (LEDR),
    .LEDG        (LEDG),
    .HEX         (HEX),
    .DE2IOIntr   (DE2IOIntr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    HSELDE2IO = 1'b1; HADDR = a; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge clk);
    @(negedge clk);
    HSELDE2IO = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = d;
    @(posedge clk);
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    HSELDE2IO = 1'b1; HADDR = a; HWRITE = 1'b0; HTRANS = 2'b10;
    @(posedge clk);
    @(negedge clk);
    HSELDE2IO = 1'b0; HTRANS = 2'b00;
    d = HREADDE2IO;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (HEX !== {56{1'b1}}) begin errors++; $display("FAIL reset_hex got %h exp %h", HEX, {56{1'b1}}); end
    checks++;
    if (DE2IOIntr !== 1'b0) begin errors++; $display("FAIL reset_intr got %b exp 0", DE2IOIntr); end
    checks++;
    if (HREADDE2IO !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", HREADDE2IO); end
    checks++;
    if (HREADYDE2IO !== 1'b1 || HRESPDE2IO !== 1'b0) begin
      errors++; $display("FAIL reset_resp got ready=%b resp=%b exp 1/0", HREADYDE2IO, HRESPDE2IO);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(8'(4 * i), rd);
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL reset_read off=%h got %h exp 0", 4 * i, rd); end
    end
  endtask

  task automatic test_leds();
    logic [31:0] rd;
    bus_write(8'h00, 32'hFFFF_FFFF);
    @(negedge clk);
    checks++;
    if (LEDR !== 18'h3FFFF) begin errors++; $display("FAIL ledr_pins got %h exp 3ffff", LEDR); end
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 32'h0003_FFFF) begin errors++; $display("FAIL ledr_read got %h exp 0003ffff", rd); end
    bus_write(8'h04, 32'h0000_01A5);
    @(negedge clk);
    checks++;
    if (LEDG !== 9'h1A5) begin errors++; $display("FAIL ledg_pins got %h exp 1a5", LEDG); end
  endtask

  task automatic test_hex();
    logic [55:0] exp_hex;
    logic [31:0] rd;
    bus_write(8'h08, 32'h89AB_CDEF);
    bus_write(8'h0C, 32'h0000_0001);
    @(negedge clk);
    exp_hex = {56{1'b1}};
    exp_hex[6:0] = 7'h0E;
    checks++;
    if (HEX !== exp_hex) begin errors++; $display("FAIL hex_digit0 got %h exp %h", HEX, exp_hex); end
    bus_write(8'h0C, 32'h0000_00FF);
    @(negedge clk);
    exp_hex = {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    checks++;
    if (HEX !== exp_hex) begin errors++; $display("FAIL hex_all got %h exp %h", HEX, exp_hex); end
    bus_read(8'h08, rd);
    checks++;
    if (rd !== 32'h89AB_CDEF) begin errors++; $display("FAIL hexval_read got %h exp 89abcdef", rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    HSELDE2IO = 1'b1; HADDR = 8'h04; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge clk);
    @(negedge clk);
    HWRITE = 1'b0; HWDATA = 32'h0000_00F0;
    @(posedge clk);
    @(negedge clk);
    HSELDE2IO = 1'b0; HTRANS = 2'b00;
    checks++;
    if (HREADDE2IO !== 32'h0000_00F0) begin
      errors++; $display("FAIL b2b_read got %h exp 000000f0", HREADDE2IO);
    end
  endtask

  task automatic test_switches();
    logic [31:0] exp_v;
    // Continuous read stream of SWSTAT: each data phase shows the current status.
    @(negedge clk);
    HSELDE2IO = 1'b1; HADDR = 8'h10; HWRITE = 1'b0; HTRANS = 2'b10;
    @(posedge clk);
`ifdef DE2IO_DEBOUNCE_EN
    @(negedge clk);
    SW = 18'h8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    SW = 18'h0;
    for (int k = 0; k < DC + 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (HREADDE2IO !== 32'h0) begin errors++; $display("FAIL sw_glitch cyc=%0d got %h exp 0", k, HREADDE2IO); end
    end
`endif
    @(negedge clk);
    SW = 18'h8;
    for (int k = 1; k <= int'(LAT) + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_v = (k >= int'(LAT)) ? 32'h8 : 32'h0;
      checks++;
      if (HREADDE2IO !== exp_v) begin
        errors++; $display("FAIL sw_latency cyc=%0d got %h exp %h", k, HREADDE2IO, exp_v);
      end
    end
    HSELDE2IO = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic test_keys();
    logic [31:0] rd;
    bus_write(8'h18, 32'h2);
    @(negedge clk);
    KEY = 4'b1101;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (DE2IOIntr !== 1'b1) begin errors++; $display("FAIL key_intr_set got %b exp 1", DE2IOIntr); end
    bus_read(8'h1C, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL keyip_set got %h exp 2", rd); end
    bus_read(8'h14, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL keystat got %h exp 2", rd); end
    bus_write(8'h1C, 32'h2);
    @(negedge clk);
    checks++;
    if (DE2IOIntr !== 1'b0) begin errors++; $display("FAIL key_intr_clr got %b exp 0", DE2IOIntr); end
    bus_read(8'h1C, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL keyip_clr got %h exp 0", rd); end
    @(negedge clk);
    KEY = 4'hF;
    repeat (LAT + 4) @(posedge clk);
    bus_read(8'h14, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL keystat_release got %h exp 0", rd); end
    bus_read(8'h1C, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL keyip_release got %h exp 0", rd); end
    // Second press: W1C data phase ends on the same edge KEYIP[1] sets.
    @(negedge clk);
    KEY = 4'b1101;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    HSELDE2IO = 1'b1; HADDR = 8'h1C; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge clk);
    @(negedge clk);
    HSELDE2IO = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = 32'h2;
    @(posedge clk);
    bus_read(8'h1C, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL keyip_set_wins got %h exp 2", rd); end
    checks++;
    if (DE2IOIntr !== 1'b1) begin errors++; $display("FAIL key_intr_set_wins got %b exp 1", DE2IOIntr); end
  endtask

  task automatic test_misc();
    logic [31:0] rd;
    bus_read(8'h40, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read got %h exp 0", rd); end
    bus_write(8'h10, 32'h0);
    bus_read(8'h10, rd);
    checks++;
    if (rd !== 32'h8) begin errors++; $display("FAIL swstat_ro got %h exp 8", rd); end
    // Reset lands on the edge that would end a LEDR write data phase.
    @(negedge clk);
    HSELDE2IO = 1'b1; HADDR = 8'h00; HWRITE = 1'b1; HTRANS = 2'b10;
    @(posedge clk);
    @(negedge clk);
    HSELDE2IO = 1'b0; HWRITE = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0001_5555;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (LEDR !== 18'h0) begin errors++; $display("FAIL reset_mid_pins got %h exp 0", LEDR); end
    bus_read(8'h00, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_mid_read got %h exp 0", rd); end
  endtask

  initial begin
    reset = 1'b1; HSELDE2IO = 1'b0; HADDR = 8'h0; HWRITE = 1'b0; HTRANS = 2'b00;
    HREADY = 1'b1; HWDATA = 32'h0; SW = 18'h0; KEY = 4'hF;
    test_reset();
    test_leds();
    test_hex();
    test_back_to_back();
    test_switches();
    test_keys();
    test_misc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
